// File: rtl/acc_pkg.sv
// acc_pkg: shared FSM state type and default widths for the stream accumulator
package acc_pkg;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} acc_state_t;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_COUNT_W = 8;
endpackage

// File: rtl/acc_adder_core.sv
// acc_adder_core: combinational a+b with unsigned carry-out and signed overflow
module acc_adder_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);
endmodule

// File: rtl/stream_accumulator.sv
// stream_accumulator: sums one frame of streamed operands and holds the result with sticky flags
module stream_accumulator
  import acc_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [COUNT_W-1:0] frame_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_carry,
  output logic               out_ovf,
  output logic               busy
);
  acc_state_t         r_state;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_ovf;
  logic [COUNT_W-1:0] r_rem;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_ovf;
  logic               w_beat;
  logic [COUNT_W-1:0] w_len_m1;

  acc_adder_core #(.WIDTH(WIDTH)) u_adder (
    .i_a    (r_acc),
    .i_b    (in_data),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovf  (w_ovf)
  );

  assign in_ready  = (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);
  assign out_sum   = r_acc;
  assign out_carry = r_carry;
  assign out_ovf   = r_ovf;
  assign w_beat    = in_valid && in_ready;
  // a zero-length frame behaves as a single-operand frame
  assign w_len_m1  = (frame_len == '0) ? '0 : frame_len - COUNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_beat) begin
          r_acc   <= in_data;
          r_carry <= 1'b0;
          r_ovf   <= 1'b0;
          r_rem   <= w_len_m1;
          r_state <= (w_len_m1 == '0) ? HOLD : ACC;
        end
        ACC: if (w_beat) begin
          r_acc   <= w_sum;
          r_carry <= r_carry | w_cout;
          r_ovf   <= r_ovf | w_ovf;
          r_rem   <= r_rem - COUNT_W'(1);
          r_state <= (r_rem == COUNT_W'(1)) ? HOLD : ACC;
        end
        HOLD: if (out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_accumulator.sv
// tb_stream_accumulator: table-driven frames with an expected-result scoreboard
module tb_stream_accumulator;
  typedef struct {
    logic [7:0]       len;
    int               n;
    logic [3:0][31:0] d;
    int               gap;
    logic [31:0]      sum;
    logic             c;
    logic             o;
  } vec_t;
  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [7:0]  frame_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        out_carry;
  logic        out_ovf;
  logic        busy;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  vec_t        vecs[8];

  stream_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .frame_len (frame_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] len, input int n, input logic [31:0] d0, d1, d2, d3,
                              input int gap, input logic [31:0] sum, input logic c, input logic o);
    vec_t v;
    v.len = len; v.n = n; v.d = {d3, d2, d1, d0}; v.gap = gap;
    v.sum = sum; v.c = c; v.o = o;
    return v;
  endfunction

  // reference: plain 33-bit sums with per-step flag detection
  function automatic exp_t model(input vec_t v);
    exp_t e;
    logic [32:0] s;
    e.sum = v.d[0]; e.c = 1'b0; e.o = 1'b0;
    for (int i = 1; i < v.n; i++) begin
      s = {1'b0, e.sum} + {1'b0, v.d[i]};
      if (s[32]) e.c = 1'b1;
      if ($signed(e.sum) + $signed(v.d[i]) != $signed({s[31], s[31:0]})) e.o = 1'b1;
      e.sum = s[31:0];
    end
    return e;
  endfunction

  task automatic drive_beat(input logic [31:0] d, input logic [7:0] len);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; frame_len = len;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    exp_t e;
    e.sum = v.sum; e.c = v.c; e.o = v.o;
    sb.push_back(e);
    for (int i = 0; i < v.n; i++) begin
      if (i > 0) repeat (v.gap) begin
        @(posedge clk); #1;
        chk("gap_busy", 32'(busy), 32'd1);
        chk("gap_valid", 32'(out_valid), 32'd0);
      end
      drive_beat(v.d[i], v.len);
      chk(i == v.n - 1 ? "latency" : "early_valid", 32'(out_valid), 32'(i == v.n - 1));
    end
  endtask

  task automatic collect(input int hold);
    exp_t e;
    int   k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk("out_valid_timeout", 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("out_sum", out_sum, e.sum);
    chk("out_carry", 32'(out_carry), 32'(e.c));
    chk("out_ovf", 32'(out_ovf), 32'(e.o));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom; frame_len = 8'd3;
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_sum", out_sum, e.sum);
      chk("hold_flags", {30'd0, out_carry, out_ovf}, {30'd0, e.c, e.o});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("taken_valid", 32'(out_valid), 32'd0);
    chk("taken_busy", 32'(busy), 32'd0);
    chk("taken_sum_kept", out_sum, e.sum);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    vecs[0] = mk(8'd4, 4, 32'd129, 32'd1055, 32'd220, 32'd20, 0, 32'd1424, 1'b0, 1'b0);
    vecs[1] = mk(8'd2, 2, 32'd50, 32'hFFFF_FFF6, 0, 0, 0, 32'd40, 1'b1, 1'b0);
    vecs[2] = mk(8'd2, 2, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 32'h8000_0000, 1'b0, 1'b1);
    vecs[3] = mk(8'd0, 1, 32'd100, 0, 0, 0, 0, 32'd100, 1'b0, 1'b0);
    vecs[4] = mk(8'd3, 3, 32'd1, 32'd2, 32'd3, 0, 2, 32'd6, 1'b0, 1'b0);
    vecs[5] = mk(8'd2, 2, 32'h8000_0000, 32'h8000_0000, 0, 0, 1, 32'd0, 1'b1, 1'b1);
    vecs[6] = mk(8'd3, 3, 32'hFFFF_FFFF, 32'd1, 32'd5, 0, 0, 32'd5, 1'b1, 1'b0);
    vecs[7] = mk(8'd1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);

    #1;
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_flags", {30'd0, out_carry, out_ovf}, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i]);
      collect(i == 0 ? 5 : 0);
    end

    for (int r = 0; r < 6; r++) begin
      v = mk(8'($urandom_range(1, 4)), 0, $urandom, $urandom, $urandom, $urandom,
             int'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
      v.n = int'(v.len);
      e = model(v);
      v.sum = e.sum; v.c = e.c; v.o = e.o;
      run_frame(v);
      collect(0);
    end

    drive_beat(32'h7FFF_FFFF, 8'd4);
    drive_beat(32'h7FFF_FFFF, 8'd4);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_sum", out_sum, 32'd0);
    chk("midrst_flags", {30'd0, out_carry, out_ovf}, 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(mk(8'd2, 2, 32'd100, 32'd30, 0, 0, 0, 32'd130, 1'b0, 1'b0));
    collect(0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
